// File: rtl/im_loader.sv
// Boot loader: frames a byte stream into 16-bit big-endian words written to instruction memory, core held in reset.
// Latency: ImWrite strobes exactly one cycle after a word's low byte is accepted.
// Backpressure: InReady is high only in byte-receiving states; the sender may stall between bytes, up to TIMEOUT cycles.
module im_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          TIMEOUT   = 65535
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [7:0]  InData,
    input  logic        InValid,
    output logic        InReady,
    output logic [15:0] ImWAddr,
    output logic [15:0] ImWData,
    output logic        ImWrite,
    output logic        CoreHold,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    localparam logic [7:0]  MAGIC_BYTE = 8'hF0;
    localparam logic [16:0] MAX_W      = 17'(MAX_WORDS);
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_MAGIC,
        S_CNT_H,
        S_CNT_L,
        S_DATA_H,
        S_DATA_L,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        xfer;
    logic        timed;
    logic        start_load;
    logic        timeout_hit;
    logic [7:0]  cnt_hi;
    logic [7:0]  hi_byte;
    logic [15:0] remaining;
    logic [7:0]  csum;
    logic [31:0] idle_cnt;
    logic [15:0] count_w;

    assign xfer        = InValid && InReady;
    assign count_w     = {cnt_hi, InData};
    assign timeout_hit = (TIMEOUT != 0) && timed && !xfer && (idle_cnt == TO_LAST);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        InReady    = 1'b0;
        timed      = 1'b0;
        start_load = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        Err        = 1'b0;
        CoreHold   = 1'b1;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                Done     = (state == S_DONE);
                Err      = (state == S_ERR);
                CoreHold = (state != S_DONE);
                if (Start) begin
                    start_load = 1'b1;
                    state_nxt  = S_MAGIC;
                end
            end
            S_MAGIC: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                if (xfer) begin
                    state_nxt = (InData == MAGIC_BYTE) ? S_CNT_H : S_ERR;
                end
            end
            S_CNT_H: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                timed   = 1'b1;
                if (xfer) begin
                    state_nxt = S_CNT_L;
                end
            end
            S_CNT_L: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                timed   = 1'b1;
                if (xfer) begin
                    if (count_w == 16'd0) begin
                        state_nxt = S_CHK;
                    end else if ({1'b0, count_w} > MAX_W) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA_H;
                    end
                end
            end
            S_DATA_H: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                timed   = 1'b1;
                if (xfer) begin
                    state_nxt = S_DATA_L;
                end
            end
            S_DATA_L: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                timed   = 1'b1;
                if (xfer) begin
                    state_nxt = (remaining == 16'd1) ? S_CHK : S_DATA_H;
                end
            end
            S_CHK: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                timed   = 1'b1;
                if (xfer) begin
                    state_nxt = (InData == csum) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // A stalled sender aborts the frame; the pending write strobe still completes.
        if (timeout_hit) begin
            state_nxt = S_ERR;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ImWAddr   <= BASE_ADDR;
            ImWData   <= 16'd0;
            ImWrite   <= 1'b0;
            cnt_hi    <= 8'd0;
            hi_byte   <= 8'd0;
            remaining <= 16'd0;
            csum      <= 8'd0;
            idle_cnt  <= 32'd0;
        end else begin
            ImWrite <= (state == S_DATA_L) && xfer;

            if (start_load) begin
                ImWAddr <= BASE_ADDR;
            end else if (ImWrite) begin
                ImWAddr <= ImWAddr + 16'd2;
            end

            if (start_load) begin
                csum <= 8'd0;
            end else if (xfer && timed && (state != S_CHK)) begin
                csum <= csum ^ InData;
            end

            if (!timed || xfer) begin
                idle_cnt <= 32'd0;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end

            if (xfer) begin
                unique case (state)
                    S_CNT_H:  cnt_hi    <= InData;
                    S_CNT_L:  remaining <= count_w;
                    S_DATA_H: hi_byte   <= InData;
                    S_DATA_L: begin
                        ImWData   <= {hi_byte, InData};
                        remaining <= remaining - 16'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a frame-level model predicts writes and outcome, a monitor checks every write strobe.
module tb_im_loader;

    localparam logic [15:0] BASE = 16'h0000;
    localparam int          MAXW = 1024;
    localparam int          TO   = 16;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [7:0]  InData = 8'd0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [15:0] ImWAddr;
    logic [15:0] ImWData;
    logic        ImWrite;
    logic        CoreHold;
    logic        Busy;
    logic        Done;
    logic        Err;

    im_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .InData(InData), .InValid(InValid),
        .InReady(InReady), .ImWAddr(ImWAddr), .ImWData(ImWData), .ImWrite(ImWrite),
        .CoreHold(CoreHold), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wr_seen = 0;
    bit          mon_en = 0;
    logic [31:0] exp_q[$];
    int          lo_q[$];
    logic [7:0]  frame[$];
    bit          is_lo[$];
    logic [31:0] mon_e;

    always @(posedge Clk) cyc <= cyc + 1;

    // Every write strobe must match the next predicted (addr,data) and land one cycle after its low byte.
    always @(negedge Clk) begin
        if (Rst && mon_en) begin
            checks++;
            if (Done && Err) begin
                failures++;
                $display("FAIL done_err_exclusive actual=%b%b required=not both", Done, Err);
            end
            if (ImWrite) begin
                wr_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected actual=%h/%h required=no write", ImWAddr, ImWData);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({ImWAddr, ImWData} !== mon_e) begin
                        failures++;
                        $display("FAIL write_addr_data actual=%h/%h required=%h/%h",
                                 ImWAddr, ImWData, mon_e[31:16], mon_e[15:0]);
                    end
                end
                checks++;
                if (lo_q.size() == 0 || lo_q[0] != cyc) begin
                    failures++;
                    $display("FAIL write_latency actual_cycle=%0d required_cycle=%0d",
                             cyc, (lo_q.size() == 0) ? -1 : lo_q[0]);
                end
                if (lo_q.size() != 0) void'(lo_q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame rules: magic, count, count words hi/lo, XOR of count and data bytes.
    // outcome: 0 = done, 1 = error, 2 = frame ends early (no verdict yet).
    function automatic void model(output int outcome, output int used, output logic [7:0] csum,
                                  output int nwr);
        logic [15:0] cnt;
        outcome = 2;
        used    = 0;
        csum    = 8'd0;
        nwr     = 0;
        is_lo.delete();
        foreach (frame[i]) is_lo.push_back(1'b0);
        if (frame.size() < 1) return;
        used = 1;
        if (frame[0] != 8'hF0) begin
            outcome = 1;
            return;
        end
        if (frame.size() < 3) begin
            used = frame.size();
            return;
        end
        cnt  = {frame[1], frame[2]};
        csum = frame[1] ^ frame[2];
        used = 3;
        if (int'(cnt) > MAXW) begin
            outcome = 1;
            return;
        end
        for (int i = 0; i < int'(cnt); i++) begin
            if (4 + 2 * i >= frame.size()) begin
                used = frame.size();
                return;
            end
            csum ^= frame[3 + 2 * i] ^ frame[4 + 2 * i];
            exp_q.push_back({BASE + 16'(2 * i), frame[3 + 2 * i], frame[4 + 2 * i]});
            is_lo[4 + 2 * i] = 1'b1;
            used += 2;
            nwr++;
        end
        if (used >= frame.size()) return;
        used++;
        outcome = (frame[used - 1] == csum) ? 0 : 1;
    endfunction

    task automatic pulse_start;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit lo, input bit gaps);
        int guard;
        guard = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                InValid = 1'b0;
                InData  = 8'($urandom);
                @(posedge Clk);
                #1;
            end
        end
        InValid = 1'b1;
        InData  = b;
        @(negedge Clk);
        while (!InReady && guard < 100) begin
            guard++;
            @(negedge Clk);
        end
        if (!InReady) chk("in_ready_wait", 32'(InReady), 32'd1);
        @(posedge Clk);
        #1;
        if (lo) lo_q.push_back(cyc);
        InValid = 1'b0;
    endtask

    task automatic run_load(input bit gaps, output int oc, output logic [7:0] cs, output int nwr);
        int used;
        model(oc, used, cs, nwr);
        pulse_start();
        chk("busy_after_start", 32'(Busy), 32'd1);
        chk("hold_after_start", 32'(CoreHold), 32'd1);
        chk("done_cleared", 32'(Done), 32'd0);
        chk("err_cleared", 32'(Err), 32'd0);
        for (int i = 0; i < used; i++) begin
            if (gaps && i == 4) begin
                pulse_start();
                chk("start_ignored_busy", 32'(Busy), 32'd1);
            end
            send_byte(frame[i], is_lo[i], gaps);
        end
        if (oc != 2) begin
            repeat (2) @(posedge Clk);
            #1;
            chk("end_done", 32'(Done), 32'(oc == 0));
            chk("end_err", 32'(Err), 32'(oc == 1));
            chk("end_hold", 32'(CoreHold), 32'(oc != 0));
            chk("end_busy", 32'(Busy), 32'd0);
            chk("end_in_ready", 32'(InReady), 32'd0);
            chk("end_pending_writes", 32'(exp_q.size()), 32'd0);
            chk("end_addr", 32'(ImWAddr), 32'(16'(BASE + 16'(2 * nwr))));
        end
    endtask

    initial begin
        int         oc;
        int         nwr;
        int         w0;
        logic [7:0] cs;

        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int         oc;
        int         nwr;
        int         w0;
        logic [7:0] cs;

        #3 Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_hold", 32'(CoreHold), 32'd1);
        chk("rst_in_ready", 32'(InReady), 32'd0);
        chk("rst_write", 32'(ImWrite), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_addr", 32'(ImWAddr), 32'(BASE));
        chk("rst_data", 32'(ImWData), 32'd0);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        mon_en = 1'b1;

        // Two-word frame; checksum 00^02^12^34^AB^CD = 42.
        frame = '{8'hF0, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        w0 = wr_seen;
        run_load(1'b0, oc, cs, nwr);
        chk("t1_csum_literal", 32'(cs), 32'h42);
        chk("t1_writes_literal", 32'(wr_seen - w0), 32'd2);
        chk("t1_done_literal", 32'(Done), 32'd1);
        chk("t1_hold_literal", 32'(CoreHold), 32'd0);
        chk("t1_addr_literal", 32'(ImWAddr), 32'h0004);

        // Empty frame goes straight to the checksum.
        frame = '{8'hF0, 8'h00, 8'h00, 8'h00};
        w0 = wr_seen;
        run_load(1'b0, oc, cs, nwr);
        chk("t2_no_writes", 32'(wr_seen - w0), 32'd0);
        chk("t2_done_literal", 32'(Done), 32'd1);

        // Bad magic byte, then recovery with a good frame.
        frame = '{8'hA5};
        run_load(1'b0, oc, cs, nwr);
        chk("t3_err_literal", 32'(Err), 32'd1);
        chk("t3_hold_literal", 32'(CoreHold), 32'd1);
        chk("t3_ready_literal", 32'(InReady), 32'd0);
        frame = '{8'hF0, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_load(1'b0, oc, cs, nwr);
        chk("t3_recover_done", 32'(Done), 32'd1);

        // One word, correct checksum is 00^01^BE^EF = 50; send 51.
        frame = '{8'hF0, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
        w0 = wr_seen;
        run_load(1'b0, oc, cs, nwr);
        chk("t4_csum_literal", 32'(cs), 32'h50);
        chk("t4_one_write", 32'(wr_seen - w0), 32'd1);
        chk("t4_err_literal", 32'(Err), 32'd1);
        chk("t4_hold_literal", 32'(CoreHold), 32'd1);

        // Stall after the count high byte: error on exactly the 16th idle cycle.
        frame = '{8'hF0, 8'h00};
        run_load(1'b0, oc, cs, nwr);
        repeat (TO - 1) @(posedge Clk);
        #1;
        chk("t5_no_err_before_timeout", 32'(Err), 32'd0);
        chk("t5_busy_before_timeout", 32'(Busy), 32'd1);
        @(posedge Clk);
        #1;
        chk("t5_timeout_err", 32'(Err), 32'd1);
        chk("t5_timeout_hold", 32'(CoreHold), 32'd1);
        chk("t5_timeout_busy", 32'(Busy), 32'd0);

        // Count 0x0401 exceeds MAX_WORDS.
        frame = '{8'hF0, 8'h04, 8'h01};
        w0 = wr_seen;
        run_load(1'b0, oc, cs, nwr);
        chk("t6_err_literal", 32'(Err), 32'd1);
        chk("t6_no_writes", 32'(wr_seen - w0), 32'd0);

        // Three words clean, then with random gaps and a mid-frame Start; checksum 07.
        frame = '{8'hF0, 8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h07};
        run_load(1'b0, oc, cs, nwr);
        chk("t7_csum_literal", 32'(cs), 32'h07);
        chk("t7_done_clean", 32'(Done), 32'd1);
        w0 = wr_seen;
        run_load(1'b1, oc, cs, nwr);
        chk("t7_done_stalled", 32'(Done), 32'd1);
        chk("t7_writes_stalled", 32'(wr_seen - w0), 32'd3);

        // Asynchronous reset while waiting for a low byte.
        frame = '{8'hF0, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        model(oc, w0, cs, nwr);
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(frame[i], is_lo[i], 1'b0);
        #2 Rst = 1'b0;
        #1;
        chk("t8_rst_hold", 32'(CoreHold), 32'd1);
        chk("t8_rst_ready", 32'(InReady), 32'd0);
        chk("t8_rst_busy", 32'(Busy), 32'd0);
        chk("t8_rst_write", 32'(ImWrite), 32'd0);
        chk("t8_rst_addr", 32'(ImWAddr), 32'(BASE));
        chk("t8_rst_data", 32'(ImWData), 32'd0);
        chk("t8_first_word_written", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        lo_q.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("t8_after_done", 32'(Done), 32'd0);
        chk("t8_after_err", 32'(Err), 32'd0);
        chk("t8_after_hold", 32'(CoreHold), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
